uart_rx_axis: RTL

- Synthesizable UART receiver. Deserializes an asynchronous 8N1 serial line into bytes.
- Presents received bytes on an AXI4-Stream master interface with a one-entry holding register.
- This is the receiving end of the team's UART link. In simulation, the UartTransmitter class drives its rx pin.
- Reports framing, overrun and (optionally) parity errors as single-cycle pulses.

---
 rtl/uart_rx_axis.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_axis.sv
// UART receiver (8N1, 5..8 data bits) with an AXI4-Stream one-entry output.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err port.
module uart_rx_axis #(
    parameter int CLK_FREQ  = 100000000,
    parameter int BAUD_RATE = 9600,
    parameter int DATA_BITS = 8
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       rx,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       framing_err,
    output logic       overrun_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    localparam int CPB = CLK_FREQ / BAUD_RATE;
    localparam int CW  = $clog2(CPB);
    localparam int IW  = $clog2(DATA_BITS);

    localparam logic [CW-1:0] HALF     = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] LAST     = CW'(CPB - 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;

    logic rx_m, rx_s, rx_q;
    logic done;
    logic good;
    logic ferr;
    logic accept;

    // rx_q is the previous rx_s, used only for falling-edge detection
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_q <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_q <= rx_s;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d;
    logic perr;
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        done    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (rx_q && !rx_s) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    state_d = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    par_d   = rx_s;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // back to IDLE in the sample cycle so a back-to-back start is seen
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef UART_RX_PARITY_EN
    assign perr = done && ((^shift_q) != par_q);
    assign good = done && rx_s && !perr;
`else
    assign good = done && rx_s;
`endif

    assign ferr   = done && !rx_s;
    assign accept = good && (!m_axis_tvalid || m_axis_tready);
    assign busy   = (state_q != S_IDLE);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            framing_err   <= 1'b0;
            overrun_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err    <= 1'b0;
`endif
        end else begin
            framing_err <= ferr;
            overrun_err <= good && !accept;
`ifdef UART_RX_PARITY_EN
            parity_err  <= perr;
`endif
            if (accept) begin
                m_axis_tdata  <= 8'(shift_q);
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule
